// File: rtl/trd_sched.sv
// trd_sched: thread scheduler and lifecycle controller for NUM_TRD hardware threads.
//
// Tracks per-thread valid/run/join state, parentage and PC, and round-robins the
// fetch pointer over running threads.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   stall_i                freeze all state; pulse outputs deassert
//   atomic_i               hold cur_trd_o while it is still running
//   init_trd_i, kill_i,
//   slp_i, wake_i, join_i  lifecycle commands (two or more at once -> sticky error_o)
//   act_trd_i, obj_trd_i   issuing thread / target thread of kill, slp, wake
//   init_pc_i              start PC of a newly allocated thread
//   pc_wr_i, nxt_pc_i      per-thread PC write enable and lane-packed new PCs
//   cur_trd_o, nxt_trd_o   fetching thread / next running thread after it
//   cur_pc_o               PC of cur_trd_o
//   new_trd_o              last allocated thread
//   valid_trd_o, run_trd_o allocated / allocated and awake
//   parent_trd_o           lane-packed parent of each thread
//   trd_full_o, idle_o     all allocated / nothing running
//   trd_of_o, invalid_op_o one-cycle pulses after a rejected command
//   error_o                sticky conflicting-command flag
module trd_sched #(
    parameter int unsigned NUM_TRD = 8,
    parameter int unsigned PC_W = 32,
    parameter logic [PC_W-1:0] START_PC = '0,
    localparam int unsigned TRD_W = $clog2(NUM_TRD)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    atomic_i,
    input  logic                    init_trd_i,
    input  logic                    kill_i,
    input  logic                    slp_i,
    input  logic                    wake_i,
    input  logic                    join_i,
    input  logic [TRD_W-1:0]        act_trd_i,
    input  logic [TRD_W-1:0]        obj_trd_i,
    input  logic [PC_W-1:0]         init_pc_i,
    input  logic [NUM_TRD-1:0]      pc_wr_i,
    input  logic [NUM_TRD*PC_W-1:0] nxt_pc_i,
    output logic [TRD_W-1:0]        cur_trd_o,
    output logic [TRD_W-1:0]        nxt_trd_o,
    output logic [PC_W-1:0]         cur_pc_o,
    output logic [TRD_W-1:0]        new_trd_o,
    output logic [NUM_TRD-1:0]      valid_trd_o,
    output logic [NUM_TRD-1:0]      run_trd_o,
    output logic [NUM_TRD*TRD_W-1:0] parent_trd_o,
    output logic                    trd_full_o,
    output logic                    idle_o,
    output logic                    trd_of_o,
    output logic                    invalid_op_o,
    output logic                    error_o
);

    logic [NUM_TRD-1:0] valid_q, valid_d, run_q, run_d, join_q, join_d;
    logic [TRD_W-1:0]   parent_q [NUM_TRD];
    logic [TRD_W-1:0]   parent_d [NUM_TRD];
    logic [PC_W-1:0]    pc_q [NUM_TRD];
    logic [PC_W-1:0]    pc_d [NUM_TRD];
    logic [TRD_W-1:0]   cur_q, cur_d, new_q, new_d;
    logic               of_q, of_d, inv_q, inv_d, err_q, err_d;

    logic [2:0]         n_cmd;
    logic               act_ok, obj_ok;
    logic [NUM_TRD-1:0] has_child;
    logic [TRD_W-1:0]   free_idx;
    logic [TRD_W-1:0]   nxt_trd;
    logic [TRD_W-1:0]   scan_idx;
    logic               found;

    assign n_cmd = 3'(init_trd_i) + 3'(kill_i) + 3'(slp_i) + 3'(wake_i) + 3'(join_i);

    // A thread may act on itself or on its direct children, and only while allocated.
    assign act_ok = valid_q[act_trd_i];
    assign obj_ok = act_ok && ((obj_trd_i == act_trd_i) || (parent_q[obj_trd_i] == act_trd_i));

    // has_child[p]: some other allocated thread names p as parent. Thread 0 is its
    // own parent, hence the i != p exclusion.
    always_comb begin
        has_child = '0;
        for (int i = 0; i < int'(NUM_TRD); i++) begin
            for (int p = 0; p < int'(NUM_TRD); p++) begin
                if (valid_q[i] && (i != p) && (parent_q[i] == TRD_W'(p))) begin
                    has_child[p] = 1'b1;
                end
            end
        end
    end

    // Lowest-index free slot; only meaningful when not full.
    always_comb begin
        free_idx = '0;
        for (int i = int'(NUM_TRD) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = TRD_W'(i);
            end
        end
    end

    // Round-robin scan starting after cur_q; power-of-two count makes the add wrap.
    always_comb begin
        nxt_trd  = cur_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k < int'(NUM_TRD); k++) begin
            scan_idx = cur_q + TRD_W'(k);
            if (!found && run_q[scan_idx]) begin
                nxt_trd = scan_idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        run_d    = run_q;
        join_d   = join_q;
        parent_d = parent_q;
        pc_d     = pc_q;
        new_d    = new_q;
        cur_d    = cur_q;
        err_d    = err_q;
        of_d     = 1'b0;
        inv_d    = 1'b0;

        // Auto-wake joined threads whose last child is gone in the registered state;
        // a command this cycle on the same thread is applied afterwards and wins.
        for (int i = 0; i < int'(NUM_TRD); i++) begin
            if (join_q[i] && !has_child[i]) begin
                run_d[i]  = 1'b1;
                join_d[i] = 1'b0;
            end
        end

        for (int i = 0; i < int'(NUM_TRD); i++) begin
            if (pc_wr_i[i]) begin
                pc_d[i] = nxt_pc_i[i*PC_W +: PC_W];
            end
        end

        if (n_cmd > 3'd1) begin
            err_d = 1'b1;
        end else if (init_trd_i) begin
            if (!act_ok) begin
                inv_d = 1'b1;
            end else if (&valid_q) begin
                of_d = 1'b1;
            end else begin
                valid_d[free_idx]  = 1'b1;
                run_d[free_idx]    = 1'b1;
                join_d[free_idx]   = 1'b0;
                parent_d[free_idx] = act_trd_i;
                pc_d[free_idx]     = init_pc_i;
                new_d              = free_idx;
            end
        end else if (kill_i) begin
            if (!obj_ok || (obj_trd_i == '0) || !valid_q[obj_trd_i]) begin
                inv_d = 1'b1;
            end else begin
                valid_d[obj_trd_i] = 1'b0;
                run_d[obj_trd_i]   = 1'b0;
                join_d[obj_trd_i]  = 1'b0;
                // Orphans move up to the grandparent.
                for (int i = 0; i < int'(NUM_TRD); i++) begin
                    if (parent_q[i] == obj_trd_i) begin
                        parent_d[i] = parent_q[obj_trd_i];
                    end
                end
            end
        end else if (slp_i) begin
            if (!obj_ok) begin
                inv_d = 1'b1;
            end else begin
                run_d[obj_trd_i] = 1'b0;
            end
        end else if (wake_i) begin
            if (!obj_ok || !valid_q[obj_trd_i]) begin
                inv_d = 1'b1;
            end else begin
                run_d[obj_trd_i]  = 1'b1;
                join_d[obj_trd_i] = 1'b0;
            end
        end else if (join_i) begin
            if (!act_ok) begin
                inv_d = 1'b1;
            end else if (has_child[act_trd_i]) begin
                run_d[act_trd_i]  = 1'b0;
                join_d[act_trd_i] = 1'b1;
            end
        end

        // Pointer uses pre-update run state; atomic cannot pin a non-running thread.
        if (!(atomic_i && run_q[cur_q])) begin
            cur_d = nxt_trd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= NUM_TRD'(1);
            run_q   <= NUM_TRD'(1);
            join_q  <= '0;
            for (int i = 0; i < int'(NUM_TRD); i++) begin
                parent_q[i] <= '0;
                pc_q[i]     <= (i == 0) ? START_PC : '0;
            end
            cur_q <= '0;
            new_q <= '0;
            of_q  <= 1'b0;
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else if (stall_i) begin
            of_q  <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            run_q    <= run_d;
            join_q   <= join_d;
            parent_q <= parent_d;
            pc_q     <= pc_d;
            cur_q    <= cur_d;
            new_q    <= new_d;
            of_q     <= of_d;
            inv_q    <= inv_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_TRD); i++) begin
            parent_trd_o[i*TRD_W +: TRD_W] = parent_q[i];
        end
    end

    assign cur_trd_o    = cur_q;
    assign nxt_trd_o    = nxt_trd;
    assign cur_pc_o     = pc_q[cur_q];
    assign new_trd_o    = new_q;
    assign valid_trd_o  = valid_q;
    assign run_trd_o    = run_q;
    assign trd_full_o   = &valid_q;
    assign idle_o       = ~|run_q;
    assign trd_of_o     = of_q;
    assign invalid_op_o = inv_q;
    assign error_o      = err_q;

endmodule
